// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit, the ALU control decoder
// and their benches: state encoding, opcodes, ALUOp and PC-source codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] ALUOP_ADDR = 2'b10;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b00;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Datapath strobes decoded from the FSM each cycle.
    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_SLT) || ((op >= OP_BEQ) && (op <= OP_JMP));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bus: IR/memory/ALU inputs and all datapath strobes and status.
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 16);
    logic [3:0]       ir_opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             alu_zero;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic [3:0]       opcode;
    logic             alu_src;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             instr_done;
    logic             halted;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ir_opcode, imem_ready, dmem_ready, alu_zero,
        output imem_req, ir_write, pc_write, pc_src, alu_op, opcode, alu_src,
               reg_dst, mem_to_reg, reg_write, mem_read, mem_write,
               instr_done, halted, bus_err, retired
    );

    modport slave (
        output ir_opcode, imem_ready, dmem_ready, alu_zero,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, opcode, alu_src,
               reg_dst, mem_to_reg, reg_write, mem_read, mem_write,
               instr_done, halted, bus_err, retired
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; flags expiry on the
// TIMEOUT-th such cycle. TIMEOUT=0 disables expiry.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic ready,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !waiting || ready)
            cnt <= '0;
        else if (cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    // A ready in the final cycle wins over expiry.
    assign expired = (TIMEOUT != 0) && waiting && !ready && (cnt == LAST);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, branch resolution, halt on illegal opcode or bus timeout.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    multicycle_ctrl_fsm_if.master bus
);
    state_t           state, state_nxt;
    logic [3:0]       opc_q;
    logic             halted_q, bus_err_q;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctl, ctl_out;
    logic             waiting, ready, expired, taken;

    assign waiting = (state == FETCH) || (state == MEM);
    assign ready   = (state == FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign taken   = ((opc_q == OP_BEQ) && bus.alu_zero) || ((opc_q == OP_BNE) && !bus.alu_zero);

    ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .ready   (ready),
        .expired (expired)
    );

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            FETCH:  if (bus.imem_ready) state_nxt = DECODE;
                    else if (expired)   state_nxt = HALT;
            DECODE: if (!is_legal(opc_q))     state_nxt = HALT;
                    else if (opc_q == OP_JMP) state_nxt = FETCH;
                    else                      state_nxt = EXEC;
            EXEC:   if ((opc_q == OP_LD) || (opc_q == OP_ST)) state_nxt = MEM;
                    else if (is_rtype(opc_q))                 state_nxt = WB;
                    else                                      state_nxt = FETCH;
            MEM:    if (bus.dmem_ready) state_nxt = (opc_q == OP_LD) ? WB : FETCH;
                    else if (expired)   state_nxt = HALT;
            WB:     state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        ctl = '0;
        unique case (state)
            FETCH: begin
                ctl.imem_req = 1'b1;
                ctl.ir_write = bus.imem_ready;
                ctl.pc_write = bus.imem_ready;
                ctl.pc_src   = PC_SEQ;
            end
            DECODE: if (opc_q == OP_JMP) begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PC_JUMP;
                ctl.instr_done = 1'b1;
            end
            EXEC: begin
                if ((opc_q == OP_LD) || (opc_q == OP_ST)) begin
                    ctl.alu_op  = ALUOP_ADDR;
                    ctl.alu_src = 1'b1;
                end else if (is_rtype(opc_q)) begin
                    ctl.alu_op = ALUOP_R;
                end else begin
                    ctl.alu_op     = ALUOP_BR;
                    ctl.pc_write   = taken;
                    ctl.pc_src     = taken ? PC_BRANCH : PC_SEQ;
                    ctl.instr_done = 1'b1;
                end
            end
            MEM: begin
                ctl.mem_read   = (opc_q == OP_LD);
                ctl.mem_write  = (opc_q == OP_ST);
                ctl.instr_done = (opc_q == OP_ST) && bus.dmem_ready;
            end
            WB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                ctl.reg_dst    = (opc_q != OP_LD);
                ctl.mem_to_reg = (opc_q == OP_LD);
            end
            default: ctl = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q     <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (ctl.ir_write) opc_q <= bus.ir_opcode;
            if (expired || ((state == DECODE) && !is_legal(opc_q))) halted_q <= 1'b1;
            if (expired) bus_err_q <= 1'b1;
            if (ctl.instr_done && (retired_q != '1)) retired_q <= retired_q + 1'b1;
        end
    end

    // Outputs are held at zero for the whole reset cycle, not just after the edge.
    assign ctl_out = rst ? '0 : ctl;

    assign bus.imem_req   = ctl_out.imem_req;
    assign bus.ir_write   = ctl_out.ir_write;
    assign bus.pc_write   = ctl_out.pc_write;
    assign bus.pc_src     = ctl_out.pc_src;
    assign bus.alu_op     = ctl_out.alu_op;
    assign bus.alu_src    = ctl_out.alu_src;
    assign bus.reg_dst    = ctl_out.reg_dst;
    assign bus.mem_to_reg = ctl_out.mem_to_reg;
    assign bus.reg_write  = ctl_out.reg_write;
    assign bus.mem_read   = ctl_out.mem_read;
    assign bus.mem_write  = ctl_out.mem_write;
    assign bus.instr_done = ctl_out.instr_done;
    assign bus.opcode     = rst ? 4'b0 : opc_q;
    assign bus.halted     = !rst && halted_q;
    assign bus.bus_err    = !rst && bus_err_q;
    assign bus.retired    = rst ? '0 : retired_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: table vectors, randomized instruction stream
// against a latency/event-count model, and hand-written halt/timeout/reset cases.
module tb_multicycle_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(16)) bus ();
    multicycle_ctrl_fsm_if #(.CNT_W(3))  bus2 ();

    multicycle_ctrl_fsm #(.CNT_W(16), .TIMEOUT(15)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    multicycle_ctrl_fsm #(.CNT_W(3),  .TIMEOUT(0))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    logic [35:0] all_out;
    logic [13:0] strobes;
    assign strobes = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op,
                      bus.alu_src, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                      bus.mem_read, bus.mem_write, bus.instr_done};
    assign all_out = {strobes, bus.opcode, bus.halted, bus.bus_err, bus.retired};

    // Observed per-instruction summary; done_k counts cycles from the first FETCH cycle.
    typedef struct packed {
        logic [5:0] done_k;
        logic [1:0] n_pcw;
        logic [1:0] last_src;
        logic [4:0] n_mrd;
        logic [4:0] n_mwr;
        logic [1:0] n_rw;
        logic [1:0] ex_aluop;
        logic       ex_alusrc;
        logic [1:0] wb_sel;
        logic [3:0] opc;
    } res_t;

    typedef struct {
        logic [3:0] op;
        int         wi;
        int         wd;
        logic       z;
        res_t       exp;
    } vec_t;

    int total = 0;
    int bad = 0;
    int exp_ret = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result from instruction-class latencies and event counts.
    function automatic res_t model(input logic [3:0] op, input int wi, input int wd, input logic z);
        res_t e;
        logic tk;
        e = '0;
        tk = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
        e.opc = op;
        e.n_pcw = 2'd1;
        if (op == OP_JMP) begin
            e.done_k = 6'(wi + 1); e.n_pcw = 2'd2; e.last_src = PC_JUMP;
        end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
            e.done_k = 6'(wi + 2); e.ex_aluop = ALUOP_BR;
            if (tk) begin e.n_pcw = 2'd2; e.last_src = PC_BRANCH; end
        end else if (op == OP_ST) begin
            e.done_k = 6'(wi + 3 + wd); e.n_mwr = 5'(wd + 1);
            e.ex_aluop = ALUOP_ADDR; e.ex_alusrc = 1'b1;
        end else if (op == OP_LD) begin
            e.done_k = 6'(wi + 4 + wd); e.n_mrd = 5'(wd + 1); e.n_rw = 2'd1;
            e.ex_aluop = ALUOP_ADDR; e.ex_alusrc = 1'b1; e.wb_sel = 2'b01;
        end else begin
            e.done_k = 6'(wi + 3); e.n_rw = 2'd1; e.ex_aluop = ALUOP_R; e.wb_sel = 2'b10;
        end
        return e;
    endfunction

    // Runs one instruction: imem_ready after wi wait cycles, dmem_ready after wd MEM waits.
    task automatic run_instr(input logic [3:0] op, input int wi, input int wd, input logic z,
                             output res_t r);
        bit done;
        done = 0;
        r = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.ir_opcode  = op;
            bus.imem_ready = (k == wi);
            bus.dmem_ready = (k == wi + 3 + wd);
            bus.alu_zero   = z;
            @(negedge clk);
            if (bus.pc_write) begin r.n_pcw = r.n_pcw + 2'd1; r.last_src = bus.pc_src; end
            if (bus.mem_read)  r.n_mrd = r.n_mrd + 5'd1;
            if (bus.mem_write) r.n_mwr = r.n_mwr + 5'd1;
            if (k == wi + 2) begin r.ex_aluop = bus.alu_op; r.ex_alusrc = bus.alu_src; end
            if (bus.reg_write) begin r.n_rw = r.n_rw + 2'd1; r.wb_sel = {bus.reg_dst, bus.mem_to_reg}; end
            if (bus.instr_done) begin r.done_k = 6'(k); r.opc = bus.opcode; done = 1; end
            @(posedge clk); #1;
        end
        if (!done) check("instr_done_within_budget", 64'd0, 64'd1);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t got, input res_t exp);
        check({tag, ".done_k"},   64'(got.done_k),    64'(exp.done_k));
        check({tag, ".pc_write"}, 64'(got.n_pcw),     64'(exp.n_pcw));
        check({tag, ".pc_src"},   64'(got.last_src),  64'(exp.last_src));
        check({tag, ".mem_read"}, 64'(got.n_mrd),     64'(exp.n_mrd));
        check({tag, ".mem_wr"},   64'(got.n_mwr),     64'(exp.n_mwr));
        check({tag, ".reg_wr"},   64'(got.n_rw),      64'(exp.n_rw));
        check({tag, ".alu_op"},   64'(got.ex_aluop),  64'(exp.ex_aluop));
        check({tag, ".alu_src"},  64'(got.ex_alusrc), 64'(exp.ex_alusrc));
        check({tag, ".wb_sel"},   64'(got.wb_sel),    64'(exp.wb_sel));
        check({tag, ".opcode"},   64'(got.opc),       64'(exp.opc));
        if (exp_ret < 65535) exp_ret++;
        check({tag, ".retired"},  64'(bus.retired),   64'(exp_ret));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs_zero", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic [3:0] legal [13];
        logic [3:0] illegal [3];
        res_t r;
        bit ok;

        legal = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR,
                  OP_AND, OP_OR, OP_SLT, OP_BEQ, OP_BNE, OP_JMP};
        illegal = '{4'b1010, 4'b1110, 4'b1111};

        //            op      wi  wd  z     done  pcw  src        mrd   mwr   rw    ex_aluop    src   wb     opc
        vecs[0]  = '{OP_ADD,  0,  0, 1'b0, '{6'd3,  2'd1, PC_SEQ,    5'd0,  5'd0, 2'd1, ALUOP_R,    1'b0, 2'b10, OP_ADD}};
        vecs[1]  = '{OP_LD,   0,  3, 1'b0, '{6'd7,  2'd1, PC_SEQ,    5'd4,  5'd0, 2'd1, ALUOP_ADDR, 1'b1, 2'b01, OP_LD}};
        vecs[2]  = '{OP_BEQ,  0,  0, 1'b1, '{6'd2,  2'd2, PC_BRANCH, 5'd0,  5'd0, 2'd0, ALUOP_BR,   1'b0, 2'b00, OP_BEQ}};
        vecs[3]  = '{OP_BNE,  0,  0, 1'b1, '{6'd2,  2'd1, PC_SEQ,    5'd0,  5'd0, 2'd0, ALUOP_BR,   1'b0, 2'b00, OP_BNE}};
        vecs[4]  = '{OP_JMP,  0,  0, 1'b0, '{6'd1,  2'd2, PC_JUMP,   5'd0,  5'd0, 2'd0, ALUOP_R,    1'b0, 2'b00, OP_JMP}};
        vecs[5]  = '{OP_ST,   2,  1, 1'b0, '{6'd6,  2'd1, PC_SEQ,    5'd0,  5'd2, 2'd0, ALUOP_ADDR, 1'b1, 2'b00, OP_ST}};
        vecs[6]  = '{OP_BNE,  1,  0, 1'b0, '{6'd3,  2'd2, PC_BRANCH, 5'd0,  5'd0, 2'd0, ALUOP_BR,   1'b0, 2'b00, OP_BNE}};
        vecs[7]  = '{OP_BEQ,  0,  0, 1'b0, '{6'd2,  2'd1, PC_SEQ,    5'd0,  5'd0, 2'd0, ALUOP_BR,   1'b0, 2'b00, OP_BEQ}};
        vecs[8]  = '{OP_SLT,  4,  0, 1'b0, '{6'd7,  2'd1, PC_SEQ,    5'd0,  5'd0, 2'd1, ALUOP_R,    1'b0, 2'b10, OP_SLT}};
        vecs[9]  = '{OP_ADD, 14,  0, 1'b0, '{6'd17, 2'd1, PC_SEQ,    5'd0,  5'd0, 2'd1, ALUOP_R,    1'b0, 2'b10, OP_ADD}};
        vecs[10] = '{OP_LD,   0, 14, 1'b0, '{6'd18, 2'd1, PC_SEQ,    5'd15, 5'd0, 2'd1, ALUOP_ADDR, 1'b1, 2'b01, OP_LD}};

        bus.ir_opcode = OP_ADD; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;
        bus2.ir_opcode = OP_JMP; bus2.imem_ready = 1'b1; bus2.dmem_ready = 1'b0; bus2.alu_zero = 1'b0;

        repeat (2) @(posedge clk);
        do_reset();

        // First cycle after reset: fetch request up, counters clear.
        @(negedge clk);
        check("first_imem_req", 64'(bus.imem_req), 64'd1);
        check("reset_retired",  64'(bus.retired),  64'd0);
        check("reset_halted",   64'({bus.halted, bus.bus_err}), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].op, vecs[i].wi, vecs[i].wd, vecs[i].z, r);
            cmp_res($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        check("no_err_ready_on_last_wait", 64'({bus.halted, bus.bus_err}), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            int wi, wd;
            logic z;
            op = legal[$urandom_range(0, 12)];
            wi = $urandom_range(0, 5);
            wd = $urandom_range(0, 5);
            z  = 1'($urandom_range(0, 1));
            run_instr(op, wi, wd, z, r);
            cmp_res($sformatf("rand%0d_op%0h", i, op), r, model(op, wi, wd, z));
        end

        // Illegal opcodes halt after DECODE, stay silent, and only reset recovers.
        for (int j = 0; j < 3; j++) begin
            bus.ir_opcode = illegal[j];
            bus.imem_ready = 1'b1;
            @(negedge clk); @(posedge clk); #1;
            bus.imem_ready = 1'b0;
            @(negedge clk);
            check($sformatf("illegal%0h_decode_not_halted", illegal[j]), 64'(bus.halted), 64'd0);
            @(posedge clk); #1;
            ok = 1;
            for (int k = 0; k < 20; k++) begin
                bus.imem_ready = 1'($urandom_range(0, 1));
                bus.dmem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (strobes !== 14'd0 || bus.halted !== 1'b1 || bus.bus_err !== 1'b0) ok = 0;
                @(posedge clk); #1;
            end
            check($sformatf("illegal%0h_halt_silent", illegal[j]), 64'(ok), 64'd1);
            bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
            do_reset();
            @(negedge clk);
            check($sformatf("illegal%0h_recover", illegal[j]),
                  64'({bus.imem_req, bus.halted, bus.retired}), 64'({1'b1, 1'b0, 16'd0}));
            @(posedge clk); #1;
        end

        // Fetch timeout: 15 not-ready cycles, then halt with bus error.
        do_reset();
        ok = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 15 && (bus.imem_req !== 1'b1 || bus.halted !== 1'b0)) ok = 0;
            if (k == 15) check("fetch_timeout_state",
                               64'({bus.imem_req, bus.halted, bus.bus_err}), 64'({1'b0, 1'b1, 1'b1}));
            @(posedge clk); #1;
        end
        check("fetch_wait_before_timeout", 64'(ok), 64'd1);

        // Data timeout on LD in MEM.
        do_reset();
        bus.ir_opcode = OP_LD;
        for (int k = 0; k < 19; k++) begin
            bus.imem_ready = (k == 0);
            @(negedge clk);
            if (k == 17) check("mem_wait_last", 64'({bus.mem_read, bus.halted}), 64'({1'b1, 1'b0}));
            if (k == 18) check("mem_timeout_state",
                               64'({bus.mem_read, bus.halted, bus.bus_err}), 64'({1'b0, 1'b1, 1'b1}));
            @(posedge clk); #1;
        end

        // Reset in the middle of MEM aborts the load without retiring.
        do_reset();
        bus.ir_opcode = OP_LD;
        for (int k = 0; k < 6; k++) begin
            bus.imem_ready = (k == 0);
            rst = (k == 4);
            @(negedge clk);
            if (k == 3) check("mid_mem_read", 64'(bus.mem_read), 64'd1);
            if (k == 4) check("mid_mem_rst_outputs_zero", 64'(all_out), 64'd0);
            if (k == 5) check("after_mid_mem_rst",
                              64'({bus.imem_req, bus.mem_read, bus.retired}), 64'({1'b1, 1'b0, 16'd0}));
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // Saturating 3-bit counter and disabled timeout on the second instance.
        rst2 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("sat_retired_counting", 64'(bus2.retired), 64'd6);
        repeat (8) @(posedge clk);
        #1;
        check("sat_retired_max", 64'(bus2.retired), 64'd7);
        bus2.imem_ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("timeout0_never_halts",
              64'({bus2.imem_req, bus2.halted, bus2.bus_err}), 64'({1'b1, 1'b0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
